// File: rtl/step_motor_ctrl.sv
// step_motor_ctrl: command-driven 4-phase stepper sequencer with linear speed ramp and position tracking
module step_motor_ctrl #(
  parameter int CNT_W        = 22,
  parameter int STEP_W       = 16,
  parameter int POS_W        = 32,
  parameter int START_PERIOD = 200000,
  parameter int RAMP_DEC     = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic              cmd_half,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [CNT_W-1:0]  cmd_period,
  input  logic              stop,
  output logic [3:0]        out,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_left,
  output logic [POS_W-1:0]  pos
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [CNT_W-1:0] START = CNT_W'(START_PERIOD);
  localparam logic [31:0] TBL = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                 4'b0110, 4'b0100, 4'b1100, 4'b1000};
  state_t             state_q;
  logic [2:0]         idx_q, idx_d;
  logic [3:0]         out_q;
  logic               done_q, dir_q, half_q, step;
  logic [STEP_W-1:0]  steps_q;
  logic [POS_W-1:0]   pos_q;
  logic [CNT_W-1:0]   cnt_q, cur_q, tgt_q, tgt_d, start_d, cur_d;
  logic [CNT_W:0]     dec_w;
  assign cmd_ready  = state_q == IDLE;
  assign busy       = state_q == RUN;
  assign done       = done_q;
  assign out        = out_q;
  assign steps_left = steps_q;
  assign pos        = pos_q;
  // next phase index, command target clamp and ramped period (saturating at the target)
  always_comb begin
    idx_d   = half_q ? (dir_q ? idx_q + 3'd1 : idx_q - 3'd1)
            : dir_q  ? {idx_q[2:1] + 2'd1, 1'b0}
            :          {idx_q[0] ? idx_q[2:1] : idx_q[2:1] - 2'd1, 1'b0};
    tgt_d   = cmd_period == '0 ? CNT_W'(1) : cmd_period;
    start_d = START > tgt_d ? START : tgt_d;
    dec_w   = {1'b0, cur_q} - (CNT_W+1)'(RAMP_DEC);
    cur_d   = (dec_w[CNT_W] || dec_w[CNT_W-1:0] < tgt_q) ? tgt_q : dec_w[CNT_W-1:0];
    step    = cnt_q == cur_q - CNT_W'(1);
  end
  // move FSM: accept commands in IDLE, time and issue steps in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      out_q   <= 4'b1000;
      done_q  <= 1'b0;
      steps_q <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      cur_q   <= START;
      tgt_q   <= START;
      dir_q   <= 1'b0;
      half_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (cmd_valid) begin
          dir_q   <= cmd_dir;
          half_q  <= cmd_half;
          tgt_q   <= tgt_d;
          steps_q <= cmd_steps;
          cnt_q   <= '0;
          cur_q   <= start_d;
          if (cmd_steps == '0) done_q <= 1'b1;
          else state_q <= RUN;
        end
      end else if (stop) begin
        state_q <= IDLE;
        steps_q <= '0;
        done_q  <= 1'b1;
      end else if (step) begin
        cnt_q   <= '0;
        idx_q   <= idx_d;
        out_q   <= TBL[{idx_d, 2'b00} +: 4];
        pos_q   <= pos_q + (dir_q ? POS_W'(1) : {POS_W{1'b1}});
        steps_q <= steps_q - STEP_W'(1);
        cur_q   <= cur_d;
        if (steps_q == STEP_W'(1)) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_step_motor_ctrl.sv
// tb_step_motor_ctrl: randomized self-checking bench for step_motor_ctrl against a cycle-level move model
module tb_step_motor_ctrl;
  localparam int CNT_W = 22, STEP_W = 16, POS_W = 8, START = 10, RAMP = 2;
  logic              clk = 1'b0, rst_n = 1'b0;
  logic              cmd_valid = 1'b0, cmd_dir = 1'b0, cmd_half = 1'b0, stop = 1'b0;
  logic [STEP_W-1:0] cmd_steps = '0;
  logic [CNT_W-1:0]  cmd_period = '0;
  logic              cmd_ready, busy, done;
  logic [3:0]        out;
  logic [STEP_W-1:0] steps_left;
  logic [POS_W-1:0]  pos;
  int                nvec = 0, nerr = 0;
  int                m_idx = 0;
  logic [POS_W-1:0]  m_pos = '0;
  int                edges[$];

  step_motor_ctrl #(.CNT_W(CNT_W), .STEP_W(STEP_W), .POS_W(POS_W),
                    .START_PERIOD(START), .RAMP_DEC(RAMP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_half(cmd_half), .cmd_steps(cmd_steps),
    .cmd_period(cmd_period), .stop(stop), .out(out), .busy(busy), .done(done),
    .steps_left(steps_left), .pos(pos));

  // free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic logic [3:0] phase(int i);
    case (i)
      0: return 4'b1000; 1: return 4'b1100; 2: return 4'b0100; 3: return 4'b0110;
      4: return 4'b0010; 5: return 4'b0011; 6: return 4'b0001; default: return 4'b1001;
    endcase
  endfunction

  function automatic int next_idx(int i, bit d, bit h);
    if (h) return (i + (d ? 1 : 7)) % 8;
    if (d) return ((i / 2 + 1) % 4) * 2;
    return (i % 2 == 1) ? i - 1 : ((i / 2 + 3) % 4) * 2;
  endfunction

  task automatic test_reset();
    @(posedge clk); #2;
    rst_n = 1'b0; cmd_valid = 1'b0; stop = 1'b0;
    #1;
    nvec++;
    if ({out, pos, steps_left, busy, done, cmd_ready} !== {4'b1000, {POS_W{1'b0}}, {STEP_W{1'b0}}, 3'b001}) begin
      nerr++;
      $display("FAIL reset: out=%b pos=%0d left=%0d busy=%b done=%b rdy=%b, want 1000/0/0/0/0/1",
               out, pos, steps_left, busy, done, cmd_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_idx = 0; m_pos = '0;
  endtask

  // one command from acceptance to the cycle after done; stop_edge>0 aborts at that edge
  task automatic do_move(input bit d, input bit h, input int n, input int per, input int stop_edge, input bit junk);
    int tgt, cur, cnt, left, e;
    bit fin;
    logic [3:0] last_out;
    edges.delete();
    tgt = per < 1 ? 1 : per;
    cur = START > tgt ? START : tgt;
    left = n; cnt = 0; e = 0; fin = 0;
    cmd_valid = 1'b1; cmd_dir = d; cmd_half = h;
    cmd_steps = STEP_W'(n); cmd_period = CNT_W'(per);
    nvec++;
    if (cmd_ready !== 1'b1) begin
      nerr++;
      $display("FAIL accept_ready: cmd_ready=%b want 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = junk;
    if (junk) begin
      cmd_dir = 1'($urandom); cmd_half = 1'($urandom);
      cmd_steps = STEP_W'($urandom); cmd_period = CNT_W'($urandom);
    end
    if (n == 0) fin = 1;
    while (!fin || e == 0) begin
      if (n != 0) begin
        e++;
        if (e == stop_edge) stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        if (e == stop_edge) begin
          left = 0; fin = 1;
        end else begin
          cnt++;
          if (cnt == cur) begin
            cnt = 0;
            m_idx = next_idx(m_idx, d, h);
            m_pos = d ? m_pos + 1'b1 : m_pos - 1'b1;
            left--;
            cur = (cur - RAMP > tgt) ? cur - RAMP : tgt;
            edges.push_back(e);
            if (left == 0) fin = 1;
          end
        end
      end else e = 1;
      nvec++;
      if ({out, pos, steps_left, busy, done, cmd_ready} !== {phase(m_idx), m_pos, STEP_W'(left), !fin, fin, fin}) begin
        nerr++;
        $display("FAIL move e=%0d: out=%b pos=%0d left=%0d busy=%b done=%b rdy=%b, want out=%b pos=%0d left=%0d busy=%b done=%b rdy=%b",
                 e, out, pos, steps_left, busy, done, cmd_ready, phase(m_idx), m_pos, left, !fin, fin, fin);
      end
      if (e > 5000) begin
        nerr++;
        $display("FAIL move_timeout: move still running after %0d cycles", e);
        fin = 1;
      end
    end
    cmd_valid = 1'b0;
    last_out = phase(m_idx);
    @(posedge clk); #1;
    nvec++;
    if ({out, pos, busy, done, cmd_ready} !== {last_out, m_pos, 3'b001}) begin
      nerr++;
      $display("FAIL after_done: out=%b pos=%0d busy=%b done=%b rdy=%b, want out=%b pos=%0d busy=0 done=0 rdy=1",
               out, pos, busy, done, cmd_ready, last_out, m_pos);
    end
  endtask

  task automatic test_full_fwd();
    int want[4] = '{10, 18, 24, 28};
    test_reset();
    do_move(1'b1, 1'b0, 4, 4, 0, 1'b0);
    nvec++;
    if (edges.size() != 4) begin
      nerr++;
      $display("FAIL full_fwd_count: steps=%0d want 4", edges.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if (edges[i] != want[i]) begin
          nerr++;
          $display("FAIL full_fwd_edge%0d: at %0d want %0d", i, edges[i], want[i]);
        end
      end
    end
    nvec++;
    if ({out, pos} !== {4'b1000, 8'd4}) begin
      nerr++;
      $display("FAIL full_fwd_end: out=%b pos=%0d want 1000/4", out, pos);
    end
  endtask

  task automatic test_half_rev_realign();
    test_reset();
    do_move(1'b0, 1'b1, 3, 4, 0, 1'b0);
    nvec++;
    if ({out, pos} !== {4'b0011, 8'hFD}) begin
      nerr++;
      $display("FAIL half_rev_end: out=%b pos=%0d want 0011/-3", out, $signed(pos));
    end
    do_move(1'b1, 1'b0, 1, 4, 0, 1'b0);
    nvec++;
    if ({out, pos} !== {4'b0001, 8'hFE}) begin
      nerr++;
      $display("FAIL realign: out=%b pos=%0d want 0001/-2", out, $signed(pos));
    end
  endtask

  task automatic test_zero_steps();
    do_move(1'b1, 1'b1, 0, 7, 0, 1'b0);
  endtask

  task automatic test_stop();
    test_reset();
    do_move(1'b1, 1'b0, 10, 4, 21, 1'b1);
    nvec++;
    if ({pos, out} !== {8'd2, 4'b0010}) begin
      nerr++;
      $display("FAIL stop_mid: pos=%0d out=%b want 2/0010", pos, out);
    end
    do_move(1'b1, 1'b1, 10, 4, 24, 1'b1);
    nvec++;
    if (pos !== 8'd4) begin
      nerr++;
      $display("FAIL stop_on_step: pos=%0d want 4", pos);
    end
  endtask

  task automatic test_min_period_wrap();
    test_reset();
    do_move(1'b1, 1'b0, 130, 0, 0, 1'b0);
    nvec++;
    if (pos !== 8'h82) begin
      nerr++;
      $display("FAIL wrap: pos=%0d want -126", $signed(pos));
    end
    nvec++;
    if (edges.size() != 130 || edges[129] - edges[128] != 1 || edges[1] - edges[0] != 8) begin
      nerr++;
      $display("FAIL min_period: steps=%0d want 130 with periods 10,8,...,1", edges.size());
    end
  endtask

  task automatic test_async_reset();
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_half = 1'b1; cmd_steps = 16'd9; cmd_period = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    nvec++;
    if ({out, pos, steps_left, busy, cmd_ready} !== {4'b1000, 8'd0, 16'd0, 2'b01}) begin
      nerr++;
      $display("FAIL async_reset: out=%b pos=%0d left=%0d busy=%b rdy=%b want 1000/0/0/0/1",
               out, pos, steps_left, busy, cmd_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_idx = 0; m_pos = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++)
      do_move(1'($urandom), 1'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 14)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0, 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_full_fwd();
    test_half_rev_realign();
    test_zero_steps();
    test_stop();
    test_min_period_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
